// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared constants for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and FSM state encoding.
package mmio_uart_pkg;

  // Register window offsets (bus_addr[2] selects between them)
  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  // STATUS register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_PARCAP  = 4;
  localparam int ST_CNT_LO  = 8;

  // Transmit FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Push while full and pop while empty are ignored; the parent owns any
// overflow policy. Storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; data path carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the data-memory bus.
// Two-word window: TXDATA (push byte) and STATUS (flags, count, overflow clear).
// Optional macro UART_PARITY_EN adds an even-parity bit before the stop bit
// and sets STATUS bit4 as a capability flag; default build is plain 8N1.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        sel,
  output logic        tx,
  output logic        tx_busy
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          wr_txdata;
  logic          wr_status;
  logic          push;
  logic          pop;
  logic          bit_end;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          overflow;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel       = (bus_addr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = sel & bus_we & (bus_addr[2] == TXDATA_OFS[2]);
  assign wr_status = sel & bus_we & (bus_addr[2] == STATUS_OFS[2]);

  // A full FIFO drops the byte even if a pop happens at the same edge
  assign push    = wr_txdata & ~fifo_full;
  assign bit_end = (baud == '0);
  // Pop from IDLE, or at stop-bit expiry to chain frames with no idle gap
  assign pop     = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign tx_busy = (state != S_IDLE) | ~fifo_empty;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture the popped byte for the frame being started
  always_ff @(posedge clk) begin
    if (pop) shreg <= fifo_dout;
  end

  // Sticky overflow: set on a dropped push, cleared by writing 1 to STATUS bit3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_txdata & fifo_full) begin
      overflow <= 1'b1;
    end else if (wr_status & bus_wdata[ST_OVF]) begin
      overflow <= 1'b0;
    end
  end

  // Serializer FSM: baud counter counts down, bit boundary at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_START;
            tx    <= 1'b0;
            baud  <= BAUD_LOAD;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            tx      <= shreg[0];
            baud    <= BAUD_LOAD;
            bit_idx <= '0;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= S_PARITY;
              tx    <= ^shreg;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
            baud  <= BAUD_LOAD;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state <= S_START;
              tx    <= 1'b0;
              baud  <= BAUD_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

  // STATUS word assembly
  always_comb begin
    status                   = '0;
    status[ST_FULL]          = fifo_full;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_BUSY]          = tx_busy;
    status[ST_OVF]           = overflow;
`ifdef UART_PARITY_EN
    status[ST_PARCAP]        = 1'b1;
`else
    status[ST_PARCAP]        = 1'b0;
`endif
    status[ST_CNT_LO +: 8]   = 8'(fifo_count);
  end

  // Read mux: TXDATA reads 0, outside the window reads 0
  always_comb begin
    bus_rdata = '0;
    if (sel && (bus_addr[2] == STATUS_OFS[2])) bus_rdata = status;
  end

endmodule
